// File: rtl/llc_req_in_buffer.sv
// llc_req_in_buffer: FIFO of incoming LLC coherence requests, current-request register and one stalled-request slot.
// Ports: clk/rst (async active-low); req_i_* upstream valid/ready request channel;
//        llc_req_in_valid + do_get_req pop handshake with the input decoder;
//        update_req_in_from_stalled / set_req_in_stalled / clr_req_in_stalled_valid stall-slot control;
//        req_in_* current request; req_in_stalled_valid; req_in_count occupancy; req_underflow_err sticky error.
module llc_req_in_buffer #(
    parameter int DEPTH     = 2,
    parameter int ADDR_BITS = 26,
    parameter int LINE_BITS = 128,
    parameter int ID_BITS   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_i_valid,
    output logic                       req_i_ready,
    input  logic [2:0]                 req_i_coh_msg,
    input  logic                       req_i_hprot,
    input  logic [ADDR_BITS-1:0]       req_i_addr,
    input  logic [LINE_BITS-1:0]       req_i_line,
    input  logic [ID_BITS-1:0]         req_i_id,
    output logic                       llc_req_in_valid,
    input  logic                       do_get_req,
    input  logic                       update_req_in_from_stalled,
    input  logic                       clr_req_in_stalled_valid,
    input  logic                       set_req_in_stalled,
    output logic                       req_in_stalled_valid,
    output logic [2:0]                 req_in_coh_msg,
    output logic                       req_in_hprot,
    output logic [ADDR_BITS-1:0]       req_in_addr,
    output logic [LINE_BITS-1:0]       req_in_line,
    output logic [ID_BITS-1:0]         req_in_id,
    output logic [$clog2(DEPTH):0]     req_in_count,
    output logic                       req_underflow_err
);
    localparam int PW = $clog2(DEPTH);
    typedef struct packed {
        logic [2:0]           coh_msg;
        logic                 hprot;
        logic [ADDR_BITS-1:0] addr;
        logic [LINE_BITS-1:0] line;
        logic [ID_BITS-1:0]   id;
    } req_t;
    req_t          mem [DEPTH];
    req_t          cur, stalled, din;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, push, pop;
    assign din   = {req_i_coh_msg, req_i_hprot, req_i_addr, req_i_line, req_i_id};
    assign empty = count == '0;
    // ready depends only on occupancy so a same-cycle pop never reopens the push slot
    assign req_i_ready = count != (PW+1)'(DEPTH);
    assign push  = req_i_valid & req_i_ready;
    // a reload from the stalled slot takes the current-request register, so the FIFO must hold
    assign pop   = do_get_req & ~empty & ~update_req_in_from_stalled;
    assign llc_req_in_valid = ~empty;
    assign req_in_count     = count;
    assign {req_in_coh_msg, req_in_hprot, req_in_addr, req_in_line, req_in_id} = cur;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            count                <= '0;
            cur                  <= '0;
            stalled              <= '0;
            req_in_stalled_valid <= 1'b0;
            req_underflow_err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + {PW'(0), push} - {PW'(0), pop};
            if (update_req_in_from_stalled) cur <= stalled;
            else if (pop) cur <= mem[rd_ptr];
            if (set_req_in_stalled) stalled <= cur;
            req_in_stalled_valid <= set_req_in_stalled | (req_in_stalled_valid & ~clr_req_in_stalled_valid);
            // the decoder sees llc_req_in_valid through a register, so an empty pop is possible; flag it
            if (do_get_req & empty & ~update_req_in_from_stalled) req_underflow_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_llc_req_in_buffer.sv
// tb_llc_req_in_buffer: table vectors, a reset-mid-stream sequence and random traffic against a queue-based model.
module tb_llc_req_in_buffer;
    localparam int DEPTH = 2, AB = 26, LB = 128, IB = 4, CW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic [2:0]    coh;
        logic          hprot;
        logic [AB-1:0] addr;
        logic [LB-1:0] line;
        logic [IB-1:0] id;
    } req_t;
    typedef struct {
        bit v, get, upd, set, clr;
        logic [AB-1:0] addr;
        logic [IB-1:0] id;
        int e_cnt;
        bit e_val, e_rdy, e_sv, e_err;
        logic [AB-1:0] e_addr;
        logic [IB-1:0] e_id;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic req_i_valid = 1'b0, req_i_ready, req_i_hprot = 1'b0;
    logic [2:0] req_i_coh_msg = '0;
    logic [AB-1:0] req_i_addr = '0;
    logic [LB-1:0] req_i_line = '0;
    logic [IB-1:0] req_i_id = '0;
    logic llc_req_in_valid, do_get_req = 1'b0, update_req_in_from_stalled = 1'b0;
    logic clr_req_in_stalled_valid = 1'b0, set_req_in_stalled = 1'b0, req_in_stalled_valid;
    logic [2:0] req_in_coh_msg;
    logic req_in_hprot, req_underflow_err;
    logic [AB-1:0] req_in_addr;
    logic [LB-1:0] req_in_line;
    logic [IB-1:0] req_in_id;
    logic [CW-1:0] req_in_count;

    llc_req_in_buffer #(.DEPTH(DEPTH), .ADDR_BITS(AB), .LINE_BITS(LB), .ID_BITS(IB)) dut (
        .clk(clk), .rst(rst),
        .req_i_valid(req_i_valid), .req_i_ready(req_i_ready),
        .req_i_coh_msg(req_i_coh_msg), .req_i_hprot(req_i_hprot), .req_i_addr(req_i_addr),
        .req_i_line(req_i_line), .req_i_id(req_i_id),
        .llc_req_in_valid(llc_req_in_valid), .do_get_req(do_get_req),
        .update_req_in_from_stalled(update_req_in_from_stalled),
        .clr_req_in_stalled_valid(clr_req_in_stalled_valid),
        .set_req_in_stalled(set_req_in_stalled), .req_in_stalled_valid(req_in_stalled_valid),
        .req_in_coh_msg(req_in_coh_msg), .req_in_hprot(req_in_hprot), .req_in_addr(req_in_addr),
        .req_in_line(req_in_line), .req_in_id(req_in_id),
        .req_in_count(req_in_count), .req_underflow_err(req_underflow_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    req_t q[$];
    req_t m_cur, m_st;
    bit m_sv, m_err;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic req_t mkreq(input logic [AB-1:0] a, input logic [IB-1:0] i);
        req_t r;
        r.coh = i[2:0];
        r.hprot = i[0];
        r.addr = a;
        r.line = LB'(a) * LB'(7) + LB'(i);
        r.id = i;
        return r;
    endfunction

    task automatic drive(input bit v, input req_t d, input bit get, input bit upd, input bit set, input bit clr);
        req_i_valid = v;
        {req_i_coh_msg, req_i_hprot, req_i_addr, req_i_line, req_i_id} = d;
        do_get_req = get;
        update_req_in_from_stalled = upd;
        set_req_in_stalled = set;
        clr_req_in_stalled_valid = clr;
    endtask

    task automatic model_reset;
        q.delete();
        m_cur = '0;
        m_st = '0;
        m_sv = 0;
        m_err = 0;
    endtask

    // Behavioural rules: update beats a pop, a pop needs a non-empty queue,
    // a push needs room measured before the edge, set beats clr.
    task automatic model_edge;
        req_t c = m_cur, s = m_st;
        int n = q.size();
        if (update_req_in_from_stalled) m_cur = s;
        else if (do_get_req && n > 0) m_cur = q.pop_front();
        else if (do_get_req) m_err = 1;
        if (set_req_in_stalled) m_st = c;
        m_sv = set_req_in_stalled || (m_sv && !clr_req_in_stalled_valid);
        if (req_i_valid && n < DEPTH) q.push_back({req_i_coh_msg, req_i_hprot, req_i_addr, req_i_line, req_i_id});
    endtask

    task automatic compare_model;
        chk("m_count", 128'(req_in_count), 128'(q.size()));
        chk("m_valid", 128'(llc_req_in_valid), 128'(q.size() != 0));
        chk("m_ready", 128'(req_i_ready), 128'(q.size() < DEPTH));
        chk("m_stalled_valid", 128'(req_in_stalled_valid), 128'(m_sv));
        chk("m_underflow", 128'(req_underflow_err), 128'(m_err));
        chk("m_cur_coh", 128'(req_in_coh_msg), 128'(m_cur.coh));
        chk("m_cur_hprot", 128'(req_in_hprot), 128'(m_cur.hprot));
        chk("m_cur_addr", 128'(req_in_addr), 128'(m_cur.addr));
        chk("m_cur_line", req_in_line, m_cur.line);
        chk("m_cur_id", 128'(req_in_id), 128'(m_cur.id));
    endtask

    task automatic tick;
        model_edge();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    initial begin
        tbl[0]  = '{1,0,0,0,0, 26'h100, 4'd3, 1, 1, 1, 0, 0, 26'h0,   4'd0};
        tbl[1]  = '{1,0,0,0,0, 26'h200, 4'd5, 2, 1, 0, 0, 0, 26'h0,   4'd0};
        tbl[2]  = '{1,1,0,0,0, 26'h300, 4'd7, 1, 1, 1, 0, 0, 26'h100, 4'd3};
        tbl[3]  = '{1,0,0,0,0, 26'h300, 4'd7, 2, 1, 0, 0, 0, 26'h100, 4'd3};
        tbl[4]  = '{0,0,0,1,0, 26'h0,   4'd0, 2, 1, 0, 1, 0, 26'h100, 4'd3};
        tbl[5]  = '{0,1,0,0,0, 26'h0,   4'd0, 1, 1, 1, 1, 0, 26'h200, 4'd5};
        tbl[6]  = '{0,0,1,0,1, 26'h0,   4'd0, 1, 1, 1, 0, 0, 26'h100, 4'd3};
        tbl[7]  = '{1,0,0,0,0, 26'h400, 4'd9, 2, 1, 0, 0, 0, 26'h100, 4'd3};
        tbl[8]  = '{0,1,0,0,0, 26'h0,   4'd0, 1, 1, 1, 0, 0, 26'h300, 4'd7};
        tbl[9]  = '{0,1,1,0,0, 26'h0,   4'd0, 1, 1, 1, 0, 0, 26'h100, 4'd3};
        tbl[10] = '{0,1,0,0,0, 26'h0,   4'd0, 0, 0, 1, 0, 0, 26'h400, 4'd9};
        tbl[11] = '{0,1,0,0,0, 26'h0,   4'd0, 0, 0, 1, 0, 1, 26'h400, 4'd9};
        tbl[12] = '{0,0,0,1,1, 26'h0,   4'd0, 0, 0, 1, 1, 1, 26'h400, 4'd9};
        tbl[13] = '{0,0,0,0,0, 26'h0,   4'd0, 0, 0, 1, 1, 1, 26'h400, 4'd9};

        model_reset();
        drive(0, '0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 128'(req_in_count), 128'(0));
        chk("rst_valid", 128'(llc_req_in_valid), 128'(0));
        chk("rst_ready", 128'(req_i_ready), 128'(1));
        chk("rst_stalled_valid", 128'(req_in_stalled_valid), 128'(0));
        chk("rst_underflow", 128'(req_underflow_err), 128'(0));
        chk("rst_cur", {req_in_coh_msg, req_in_hprot, req_in_addr, req_in_id, req_in_line[93:0]}, 128'(0));
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].v, mkreq(tbl[i].addr, tbl[i].id), tbl[i].get, tbl[i].upd, tbl[i].set, tbl[i].clr);
            tick();
            chk($sformatf("tbl%0d_count", i), 128'(req_in_count), 128'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_valid", i), 128'(llc_req_in_valid), 128'(tbl[i].e_val));
            chk($sformatf("tbl%0d_ready", i), 128'(req_i_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_stalled_valid", i), 128'(req_in_stalled_valid), 128'(tbl[i].e_sv));
            chk($sformatf("tbl%0d_underflow", i), 128'(req_underflow_err), 128'(tbl[i].e_err));
            chk($sformatf("tbl%0d_addr", i), 128'(req_in_addr), 128'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_id", i), 128'(req_in_id), 128'(tbl[i].e_id));
        end

        drive(1, mkreq(26'h500, 4'd1), 0, 0, 0, 0);
        tick();
        drive(1, mkreq(26'h600, 4'd2), 0, 0, 1, 0);
        tick();
        drive(0, '0, 0, 0, 0, 0);
        chk("pre_rst_count", 128'(req_in_count), 128'(2));
        chk("pre_rst_stalled_valid", 128'(req_in_stalled_valid), 128'(1));
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_count", 128'(req_in_count), 128'(0));
        chk("mid_rst_valid", 128'(llc_req_in_valid), 128'(0));
        chk("mid_rst_ready", 128'(req_i_ready), 128'(1));
        chk("mid_rst_stalled_valid", 128'(req_in_stalled_valid), 128'(0));
        chk("mid_rst_underflow", 128'(req_underflow_err), 128'(0));
        chk("mid_rst_addr", 128'(req_in_addr), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 1) == 1, mkreq(AB'($urandom), IB'($urandom)),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/llc_req_in_buffer.md
Name: llc_req_in_buffer

Overview:
- Buffers LLC coherence requests arriving from the NoC request plane.
- Drives llc_req_in_valid into the LLC input decoder and presents the popped request as the current request to the LLC datapath.
- Holds one stalled request (set-conflict / eviction stall) and replays it when the decoder resumes it.
- Sits directly upstream of the input decoder; consumes its do_get_req, update_req_in_from_stalled and clr_req_in_stalled_valid.

Parameters:
- DEPTH, 2, FIFO entries (power of 2, ≥2)
- ADDR_BITS, 26, line address width
- LINE_BITS, 128, cache line data width
- ID_BITS, 4, requester id width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_i_valid  in  1  upstream request valid
- req_i_ready  out  1  upstream ready; = !full, registered-state only, no combinational path from do_get_req
- req_i_coh_msg  in  3  coherence message type
- req_i_hprot  in  1  hprot
- req_i_addr  in  ADDR_BITS  line address
- req_i_line  in  LINE_BITS  write data
- req_i_id  in  ID_BITS  requester id
- llc_req_in_valid  out  1  FIFO non-empty, to decoder
- do_get_req  in  1  decoder pops FIFO head into current request
- update_req_in_from_stalled  in  1  decoder reloads current request from stalled register
- clr_req_in_stalled_valid  in  1  decoder clears stalled flag
- set_req_in_stalled  in  1  LLC FSM parks current request as stalled
- req_in_stalled_valid  out  1  stalled register occupied
- req_in_coh_msg, req_in_hprot, req_in_addr, req_in_line, req_in_id  out  3/1/ADDR_BITS/LINE_BITS/ID_BITS  current request register
- req_in_count  out  $clog2(DEPTH)+1  FIFO occupancy
- req_underflow_err  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=0, async):
  - FIFO empty; pointers 0; count 0.
  - llc_req_in_valid=0, req_i_ready=1, req_in_stalled_valid=0, req_underflow_err=0.
  - All current and stalled request fields = 0.
- FIFO push:
  - Condition: req_i_valid & req_i_ready at posedge.
  - Entry written at wr_ptr; wr_ptr wraps modulo DEPTH.
- FIFO pop:
  - Condition: do_get_req & !empty & !update_req_in_from_stalled.
  - Head copied into current request register at the same edge; rd_ptr advances with wrap.
  - Current request outputs are valid the cycle after the pop edge (1-cycle latency).
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both succeed.
- Full:
  - req_i_ready=0 even if do_get_req is high that cycle; the push slot reopens the next cycle.
- Empty pop (do_get_req & empty):
  - Ignored; current request holds; req_underflow_err set and held until reset.
  - Required because the decoder samples llc_req_in_valid through a register.
- update_req_in_from_stalled:
  - Current request register loads the stalled register at the edge.
  - If do_get_req is also high, update wins and the FIFO does not pop.
- set_req_in_stalled:
  - Stalled register loads the current request; req_in_stalled_valid=1 next cycle.
  - If already valid: overwrite; no error.
- clr_req_in_stalled_valid clears the flag; stalled data is retained.
- set and clr in the same cycle: set wins, flag stays 1.
- llc_req_in_valid = (count!=0), registered state.
- req_in_count updates one edge after push/pop.
- Reset mid-operation: all state returns to reset values immediately (async); in-flight data is discarded.

Test Plan:
- Reset, then push A (addr 0x100, id 3) then B (addr 0x200, id 5); pulse do_get_req → req_in_addr=0x100, req_in_id=3 one cycle later; count 2→1; llc_req_in_valid stays 1.
- Push 2 with DEPTH=2, hold req_i_valid with C → req_i_ready=0, count=2; pop one → ready=1 next cycle; C accepted; order A,B,C preserved across pointer wrap.
- Current=A; pulse set_req_in_stalled → req_in_stalled_valid=1. Pop B → current=B. Pulse update_req_in_from_stalled + clr_req_in_stalled_valid together → current=A, stalled_valid=0, count unchanged.
- do_get_req and update_req_in_from_stalled together with count=1 → current loads stalled value; count stays 1; no underflow.
- do_get_req with FIFO empty → req_underflow_err=1 and stays 1; current request unchanged; set_req_in_stalled with clr the same cycle → stalled_valid=1.
- Assert rst low mid-stream with count=2, stalled_valid=1 → immediately count=0, llc_req_in_valid=0, req_i_ready=1, stalled_valid=0, err=0.
